// File: rtl/program_loader_pkg.sv
// program_loader_pkg: instruction word geometry, opcode set and loader FSM states
package program_loader_pkg;
  localparam int OPCODE_W = 5;
  localparam int OPER_W = 11;
  localparam int INSTR_W = OPCODE_W + OPER_W;
  localparam logic [OPER_W-1:0] MAX_ADDR = '1;
  typedef enum logic [OPCODE_W-1:0] {
    HLT  = 5'd0,
    STO  = 5'd1,
    LD   = 5'd2,
    LDI  = 5'd3,
    ADD  = 5'd4,
    ADDI = 5'd5,
    SUB  = 5'd6,
    SUBI = 5'd7
  } opcode_t;
  localparam logic [OPCODE_W-1:0] MAX_OP = SUBI;
  typedef enum logic [1:0] {WAIT_HI, WAIT_LO, WRITE, DONE} loader_state_t;
  function automatic logic [OPCODE_W-1:0] opcodeOf(logic [INSTR_W-1:0] word);
    return word[INSTR_W-1 -: OPCODE_W];
  endfunction
endpackage

// File: rtl/program_loader_if.sv
// program_loader_if: UART byte input and program-memory write port of the loader
interface program_loader_if;
  import program_loader_pkg::*;
  logic rx_done;
  logic [7:0] rx_data;
  logic start;
  logic prog_we;
  logic [OPER_W-1:0] prog_addr;
  logic [INSTR_W-1:0] prog_data;
  logic load_busy;
  logic load_done;
  logic cpu_run;
  logic err_opcode;
  logic overflow;
  modport master (
    output rx_done, rx_data, start,
    input prog_we, prog_addr, prog_data, load_busy, load_done, cpu_run, err_opcode, overflow
  );
  modport slave (
    input rx_done, rx_data, start,
    output prog_we, prog_addr, prog_data, load_busy, load_done, cpu_run, err_opcode, overflow
  );
endinterface

// File: rtl/program_loader.sv
// program_loader: assembles UART byte pairs into instruction words and writes them to program memory
module program_loader
  import program_loader_pkg::*;
(
  input logic clk,
  input logic reset,
  program_loader_if.slave bus
);
  loader_state_t state, nextState;
  logic [OPER_W-1:0] addr, nextAddr, nextProgAddr;
  logic [7:0] hiByte, nextHi;
  logic [INSTR_W-1:0] nextProgData;
  logic nextWe, nextErr, nextOvf, isHlt, finish;
  // the word being written is already held in prog_data during WRITE
  assign isHlt = opcodeOf(bus.prog_data) == HLT;
  assign finish = isHlt || addr == MAX_ADDR;
  assign bus.cpu_run = bus.load_done;
  always_comb begin
    nextState = state;
    nextAddr = addr;
    nextHi = hiByte;
    nextWe = 1'b0;
    nextProgAddr = bus.prog_addr;
    nextProgData = bus.prog_data;
    nextErr = bus.err_opcode;
    nextOvf = bus.overflow;
    case (state)
      WAIT_HI: begin
        nextHi = bus.rx_done ? bus.rx_data : hiByte;
        nextState = bus.rx_done ? WAIT_LO : WAIT_HI;
      end
      WAIT_LO: if (bus.rx_done) begin
        nextWe = 1'b1;
        nextProgAddr = addr;
        nextProgData = {hiByte, bus.rx_data};
        nextState = WRITE;
      end
      WRITE: begin
        nextErr = bus.err_opcode || opcodeOf(bus.prog_data) > MAX_OP;
        nextOvf = bus.overflow || (!isHlt && addr == MAX_ADDR);
        nextAddr = finish ? addr : addr + 1'b1;
        nextHi = (!finish && bus.rx_done) ? bus.rx_data : hiByte;
        nextState = finish ? DONE : (bus.rx_done ? WAIT_LO : WAIT_HI);
      end
      DONE: if (bus.start) begin
        nextAddr = '0;
        nextErr = 1'b0;
        nextOvf = 1'b0;
        nextState = WAIT_HI;
      end
      default: nextState = WAIT_HI;
    endcase
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= WAIT_HI;
      addr <= '0;
      hiByte <= '0;
      bus.prog_we <= 1'b0;
      bus.prog_addr <= '0;
      bus.prog_data <= '0;
      bus.load_busy <= 1'b1;
      bus.load_done <= 1'b0;
      bus.err_opcode <= 1'b0;
      bus.overflow <= 1'b0;
    end else begin
      state <= nextState;
      addr <= nextAddr;
      hiByte <= nextHi;
      bus.prog_we <= nextWe;
      bus.prog_addr <= nextProgAddr;
      bus.prog_data <= nextProgData;
      bus.load_busy <= nextState != DONE;
      bus.load_done <= nextState == DONE;
      bus.err_opcode <= nextErr;
      bus.overflow <= nextOvf;
    end
endmodule

// File: tb/tb_program_loader.sv
// tb_program_loader: byte-level reference model of the loader checked against every memory write and flag
module tb_program_loader;
  import program_loader_pkg::*;
  typedef struct {logic [10:0] a; logic [15:0] d;} wr_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int tests = 0;
  int fails = 0;
  wr_t expQ[$];
  wr_t wrLog[$];
  bit mDone, mHasHi, mErr, mOvf;
  logic [7:0] mHi;
  int mAddr;
  bit prevWe = 0;
  program_loader_if bus();
  program_loader dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic modelByte(logic [7:0] b);
    logic [15:0] w;
    if (mDone) return;
    if (!mHasHi) begin
      mHasHi = 1;
      mHi = b;
      return;
    end
    mHasHi = 0;
    w = {mHi, b};
    expQ.push_back('{a: 11'(mAddr), d: w});
    if (w[15:11] > 5'd7) mErr = 1;
    if (w[15:11] == 5'd0) mDone = 1;
    else if (mAddr == 2047) begin
      mDone = 1;
      mOvf = 1;
    end else mAddr++;
  endtask
  task automatic sendByte(logic [7:0] b, int gap);
    bus.rx_done = 1'b1;
    bus.rx_data = b;
    modelByte(b);
    @(negedge clk);
    bus.rx_done = 1'b0;
    bus.rx_data = $urandom;
    repeat (gap) @(negedge clk);
  endtask
  task automatic sendWord(logic [15:0] w, int gap);
    sendByte(w[15:8], gap);
    sendByte(w[7:0], gap);
  endtask
  task automatic startPulse();
    repeat (2) @(negedge clk);
    bus.start = 1'b1;
    if (mDone) begin
      mDone = 0;
      mAddr = 0;
      mErr = 0;
      mOvf = 0;
      mHasHi = 0;
    end
    @(negedge clk);
    bus.start = 1'b0;
    wrLog.delete();
  endtask
  task automatic doReset(bit checkValues);
    reset = 1'b1;
    {mDone, mHasHi, mErr, mOvf} = '0;
    mAddr = 0;
    expQ.delete();
    wrLog.delete();
    #2;
    if (checkValues) begin
      check("rst_we", bus.prog_we, 0);
      check("rst_addr", bus.prog_addr, 0);
      check("rst_data", bus.prog_data, 0);
      check("rst_busy", bus.load_busy, 1);
      check("rst_done", bus.load_done, 0);
      check("rst_run", bus.cpu_run, 0);
      check("rst_err", bus.err_opcode, 0);
      check("rst_ovf", bus.overflow, 0);
    end
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask
  task automatic checkFlags(string name);
    repeat (3) @(negedge clk);
    check({name, "_done"}, bus.load_done, mDone);
    check({name, "_run"}, bus.cpu_run, mDone);
    check({name, "_busy"}, bus.load_busy, !mDone);
    check({name, "_err"}, bus.err_opcode, mErr);
    check({name, "_ovf"}, bus.overflow, mOvf);
    check({name, "_pending"}, expQ.size(), 0);
  endtask
  initial forever begin
    @(posedge clk);
    #1;
    if (reset) prevWe = 0;
    else begin
      if (bus.prog_we) begin
        check("we_pulse", prevWe, 0);
        if (expQ.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_write: got %0h@%0h expected none", bus.prog_data, bus.prog_addr);
        end else begin
          wr_t e;
          e = expQ.pop_front();
          check("wr_addr", bus.prog_addr, e.a);
          check("wr_data", bus.prog_data, e.d);
        end
        wrLog.push_back('{a: bus.prog_addr, d: bus.prog_data});
      end
      prevWe = bus.prog_we;
    end
  end
  initial begin
    logic [4:0] op;
    int n;
    bus.rx_done = 1'b0;
    bus.rx_data = '0;
    bus.start = 1'b0;
    @(negedge clk);
    doReset(1);
    sendWord(16'h1805, 1);
    sendWord(16'h0000, 0);
    checkFlags("ldi_hlt");
    check("ldi_n", wrLog.size(), 2);
    check("ldi_w0", {5'(0), wrLog[0].a, wrLog[0].d}, {16'h0000, 16'h1805});
    check("ldi_w1", {5'(0), wrLog[1].a, wrLog[1].d}, {16'h0001, 16'h0000});
    check("ldi_done_lit", bus.load_done, 1);
    startPulse();
    sendWord(16'h2003, 2);
    sendByte(8'h39, 0);
    repeat (4) @(negedge clk);
    check("half_n", wrLog.size(), 1);
    check("half_busy", bus.load_busy, 1);
    sendByte(8'hFF, 0);
    sendWord(16'h0000, 0);
    checkFlags("add_subi");
    check("subi_w1", {5'(0), wrLog[1].a, wrLog[1].d}, {16'h0001, 16'h39FF});
    startPulse();
    sendWord(16'hF800, 0);
    sendWord(16'h0000, 1);
    checkFlags("badop");
    check("badop_err_lit", bus.err_opcode, 1);
    check("badop_w0", {5'(0), wrLog[0].a, wrLog[0].d}, {16'h0000, 16'hF800});
    repeat (3) sendByte(8'h18, 1);
    checkFlags("done_ignore");
    check("done_ignore_n", wrLog.size(), 2);
    startPulse();
    check("restart_done", bus.load_done, 0);
    check("restart_err", bus.err_opcode, 0);
    sendWord(16'h1a2b, 0);
    sendWord(16'h0000, 0);
    checkFlags("restart");
    check("restart_w0", {5'(0), wrLog[0].a, wrLog[0].d}, {16'h0000, 16'h1a2b});
    sendByte(8'h18, 0);
    @(negedge clk);
    doReset(0);
    sendWord(16'h0801, 0);
    sendWord(16'h0000, 0);
    checkFlags("midword_rst");
    check("midword_w0", {5'(0), wrLog[0].a, wrLog[0].d}, {16'h0000, 16'h0801});
    startPulse();
    for (int i = 0; i < 2048; i++) sendWord({5'd3, 11'($urandom)}, 0);
    checkFlags("ovf");
    check("ovf_lit", bus.overflow, 1);
    check("ovf_n", wrLog.size(), 2048);
    check("ovf_last", wrLog[2047].a, 11'h7FF);
    for (int i = 0; i < 6; i++) sendByte(8'($urandom), 0);
    checkFlags("ovf_ignore");
    for (int r = 0; r < 40; r++) begin
      if ($urandom_range(0, 5) == 0) begin
        @(negedge clk);
        doReset(0);
      end else startPulse();
      n = $urandom_range(1, 30);
      for (int i = 0; i < n; i++) begin
        op = ($urandom_range(0, 12) == 0) ? 5'd0 :
             ($urandom_range(0, 3) == 0) ? 5'($urandom_range(8, 31)) : 5'($urandom_range(1, 7));
        sendWord({op, 11'($urandom)}, $urandom_range(0, 2));
        if ($urandom_range(0, 15) == 0) startPulse();
      end
      if ($urandom_range(0, 3) == 0) begin
        sendByte(8'($urandom), 0);
        @(negedge clk);
        doReset(0);
      end
      sendWord({5'd0, 11'($urandom)}, $urandom_range(0, 1));
      if ($urandom_range(0, 1) == 0) sendWord(16'($urandom), 0);
      checkFlags("rand");
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
